// File: rtl/reg_mux_pkg.sv
// Shared system package: occupancy encoding for the 2-entry output buffers
// used by the mux, ALU and register-file datapaths.
package reg_mux_pkg;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'b00,
      OCC_ONE   = 2'b01,
      OCC_FULL  = 2'b10
   } occ_state_e;

endpackage : reg_mux_pkg

// File: rtl/skid_buf.sv
// Two-entry output buffer (head + skid). The head register drives the
// output directly, so data and valid are registered. The head is cleared
// whenever the buffer empties, so the data output reads 0 while invalid.
module skid_buf
   import reg_mux_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  push_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  ready_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  valid_o,
   output logic                  full_o
);

   occ_state_e            state_q, state_d;
   logic [DATA_WIDTH-1:0] head_q, head_d;
   logic [DATA_WIDTH-1:0] skid_q, skid_d;
   logic                  valid_q, valid_d;
   logic                  pop_s;

   assign pop_s   = valid_q & ready_i;
   assign data_o  = head_q;
   assign valid_o = valid_q;
   assign full_o  = (state_q == OCC_FULL);

   // Occupancy state and storage registers; reset discards all buffered words.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= OCC_EMPTY;
         head_q  <= {DATA_WIDTH{1'b0}};
         skid_q  <= {DATA_WIDTH{1'b0}};
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         skid_q  <= skid_d;
         valid_q <= valid_d;
      end
   end

   // Next-state logic: push/pop handling for each occupancy level.
   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      skid_d  = skid_q;
      case (state_q)
         OCC_EMPTY: begin
            if (push_i) begin
               state_d = OCC_ONE;
               head_d  = data_i;
            end else begin
               state_d = OCC_EMPTY;
            end
         end
         OCC_ONE: begin
            if (push_i && pop_s) begin
               // head leaves and the new word takes its place
               state_d = OCC_ONE;
               head_d  = data_i;
            end else if (push_i) begin
               state_d = OCC_FULL;
               skid_d  = data_i;
            end else if (pop_s) begin
               state_d = OCC_EMPTY;
               head_d  = {DATA_WIDTH{1'b0}};
            end else begin
               state_d = OCC_ONE;
            end
         end
         OCC_FULL: begin
            // ready is low while full, so push_i is never honoured here
            if (pop_s) begin
               state_d = OCC_ONE;
               head_d  = skid_q;
               skid_d  = {DATA_WIDTH{1'b0}};
            end else begin
               state_d = OCC_FULL;
            end
         end
         default: begin
            state_d = OCC_EMPTY;
            head_d  = {DATA_WIDTH{1'b0}};
            skid_d  = {DATA_WIDTH{1'b0}};
         end
      endcase
      valid_d = (state_d != OCC_EMPTY);
   end

endmodule : skid_buf

// File: rtl/reg_mux.sv
// N:1 registered multiplexer: select decode, per-channel ready fan-out and
// out-of-range select flag in front of a 2-entry skid buffer.
module reg_mux
   import reg_mux_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_CH     = 4,
   parameter int SEL_WIDTH  = $clog2(NUM_CH)
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic [NUM_CH*DATA_WIDTH-1:0] In_Data,
   input  logic [NUM_CH-1:0]            In_Valid,
   output logic [NUM_CH-1:0]            In_Ready,
   input  logic [SEL_WIDTH-1:0]         Sel,
   output logic [DATA_WIDTH-1:0]        Out_Data,
   output logic                         Out_Valid,
   input  logic                         Out_Ready,
   output logic                         Sel_Err
);

   // one extra bit so NUM_CH itself is representable for the range check
   localparam logic [SEL_WIDTH:0] NUM_CH_W = (SEL_WIDTH+1)'(NUM_CH);

   logic [NUM_CH-1:0]     sel_onehot_s;
   logic [DATA_WIDTH-1:0] mux_data_s;
   logic                  sel_ok_s;
   logic                  full_s;
   logic                  push_s;
   logic                  sel_err_q, sel_err_d;

   assign sel_ok_s = ({1'b0, Sel} < NUM_CH_W);

   // Select decode and AND-OR data mux; an out-of-range select matches no channel.
   always_comb begin
      sel_onehot_s = {NUM_CH{1'b0}};
      mux_data_s   = {DATA_WIDTH{1'b0}};
      for (int k = 0; k < NUM_CH; k++) begin
         sel_onehot_s[k] = ({1'b0, Sel} == (SEL_WIDTH+1)'(k));
         mux_data_s      = mux_data_s
                         | (In_Data[k*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{sel_onehot_s[k]}});
      end
   end

   // Ready depends only on Sel and the registered full flag.
   assign In_Ready  = sel_onehot_s & {NUM_CH{~full_s}};
   assign push_s    = |(In_Valid & In_Ready);
   assign sel_err_d = ~sel_ok_s & (|In_Valid);
   assign Sel_Err   = sel_err_q;

   // Registered one-cycle flag for a bad select presented with any valid.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         sel_err_q <= 1'b0;
      end else begin
         sel_err_q <= sel_err_d;
      end
   end

   skid_buf #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_skid_buf (
      .clk_i   (CLK),
      .rst_ni  (RST),
      .push_i  (push_s),
      .data_i  (mux_data_s),
      .ready_i (Out_Ready),
      .data_o  (Out_Data),
      .valid_o (Out_Valid),
      .full_o  (full_s)
   );

endmodule : reg_mux

// File: tb/tb_reg_mux.sv
// Directed self-checking bench for reg_mux: a 4-channel instance for the
// main scenarios and a 3-channel instance for the out-of-range select.
module tb_reg_mux;

   logic        CLK;
   logic        RST;

   logic [31:0] in_data;
   logic [3:0]  in_valid;
   logic [3:0]  in_ready;
   logic [1:0]  sel;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic        sel_err;

   logic [23:0] in_data3;
   logic [2:0]  in_valid3;
   logic [2:0]  in_ready3;
   logic [1:0]  sel3;
   logic [7:0]  out_data3;
   logic        out_valid3;
   logic        out_ready3;
   logic        sel_err3;

   int total;
   int bad;

   reg_mux #(.DATA_WIDTH(8), .NUM_CH(4)) dut (
      .CLK(CLK), .RST(RST), .In_Data(in_data), .In_Valid(in_valid),
      .In_Ready(in_ready), .Sel(sel), .Out_Data(out_data),
      .Out_Valid(out_valid), .Out_Ready(out_ready), .Sel_Err(sel_err)
   );

   reg_mux #(.DATA_WIDTH(8), .NUM_CH(3)) dut3 (
      .CLK(CLK), .RST(RST), .In_Data(in_data3), .In_Valid(in_valid3),
      .In_Ready(in_ready3), .Sel(sel3), .Out_Data(out_data3),
      .Out_Valid(out_valid3), .Out_Ready(out_ready3), .Sel_Err(sel_err3)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      RST = 1'b0; in_data = 32'h0; in_valid = 4'h0; sel = 2'd0; out_ready = 1'b0;
      in_data3 = 24'h0; in_valid3 = 3'h0; sel3 = 2'd0; out_ready3 = 1'b0;
      #12;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
      total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", out_data); end
      total++; if (sel_err !== 1'b0) begin bad++; $display("FAIL reset_selerr got=%b exp=0", sel_err); end
      total++; if (in_ready !== 4'b0001) begin bad++; $display("FAIL reset_ready got=%b exp=0001", in_ready); end
      @(negedge CLK);
      RST = 1'b1;
      tick();
   endtask

   task automatic test_single_push();
      out_ready = 1'b1; sel = 2'd2; in_data = 32'h00A5_0000; in_valid = 4'b0100;
      #1;
      total++; if (in_ready !== 4'b0100) begin bad++; $display("FAIL single_ready got=%b exp=0100", in_ready); end
      tick();
      in_valid = 4'b0000;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", out_valid); end
      total++; if (out_data !== 8'hA5) begin bad++; $display("FAIL single_data got=%h exp=a5", out_data); end
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drain_valid got=%b exp=0", out_valid); end
      total++; if (out_data !== 8'h00) begin bad++; $display("FAIL single_drain_data got=%h exp=00", out_data); end
   endtask

   task automatic test_ignore_nonsel();
      out_ready = 1'b0; sel = 2'd0; in_data = 32'hDDCC_BB00; in_valid = 4'b1110;
      tick();
      tick();
      in_valid = 4'b0000;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL nonsel_valid got=%b exp=0", out_valid); end
      total++; if (in_ready !== 4'b0001) begin bad++; $display("FAIL nonsel_ready got=%b exp=0001", in_ready); end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0; sel = 2'd1;
      in_data = 32'h0000_1100; in_valid = 4'b0010;
      tick();
      total++; if (out_data !== 8'h11) begin bad++; $display("FAIL bp_first got=%h exp=11", out_data); end
      in_data = 32'h0000_2200;
      tick();
      total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL bp_full_ready got=%b exp=0000", in_ready); end
      in_data = 32'h0000_3300;
      tick();
      total++; if (out_data !== 8'h11 || out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold got=%h/%b exp=11/1", out_data, out_valid); end
      total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL bp_hold_ready got=%b exp=0000", in_ready); end
      out_ready = 1'b1;
      tick();
      total++; if (out_data !== 8'h22 || out_valid !== 1'b1) begin bad++; $display("FAIL bp_second got=%h/%b exp=22/1", out_data, out_valid); end
      total++; if (in_ready !== 4'b0010) begin bad++; $display("FAIL bp_reopen_ready got=%b exp=0010", in_ready); end
      tick();
      in_valid = 4'b0000;
      total++; if (out_data !== 8'h33 || out_valid !== 1'b1) begin bad++; $display("FAIL bp_third got=%h/%b exp=33/1", out_data, out_valid); end
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b exp=0", out_valid); end
   endtask

   task automatic test_streaming();
      logic [7:0] w;
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         w = 8'h40 + 8'(i);
         sel = 2'(i % 4);
         in_data = {4{~w}};
         in_data[(i % 4)*8 +: 8] = w;
         in_valid = 4'b1111;
         tick();
         total++; if (out_valid !== 1'b1 || out_data !== w) begin bad++; $display("FAIL stream_%0d got=%h/%b exp=%h/1", i, out_data, out_valid, w); end
      end
      in_valid = 4'b0000;
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_end got=%b exp=0", out_valid); end
   endtask

   task automatic test_bad_sel();
      out_ready3 = 1'b0; sel3 = 2'd0; in_data3 = 24'h00_005A; in_valid3 = 3'b001;
      tick();
      sel3 = 2'd3; in_valid3 = 3'b111; in_data3 = 24'h77_6655;
      #1;
      total++; if (in_ready3 !== 3'b000) begin bad++; $display("FAIL badsel_ready got=%b exp=000", in_ready3); end
      tick();
      in_valid3 = 3'b000;
      total++; if (sel_err3 !== 1'b1) begin bad++; $display("FAIL badsel_pulse got=%b exp=1", sel_err3); end
      total++; if (out_data3 !== 8'h5A || out_valid3 !== 1'b1) begin bad++; $display("FAIL badsel_hold got=%h/%b exp=5a/1", out_data3, out_valid3); end
      tick();
      total++; if (sel_err3 !== 1'b0) begin bad++; $display("FAIL badsel_once got=%b exp=0", sel_err3); end
      total++; if (out_data3 !== 8'h5A || out_valid3 !== 1'b1) begin bad++; $display("FAIL badsel_state got=%h/%b exp=5a/1", out_data3, out_valid3); end
      out_ready3 = 1'b1; in_valid3 = 3'b111;
      tick();
      in_valid3 = 3'b000;
      total++; if (out_valid3 !== 1'b0 || sel_err3 !== 1'b1) begin bad++; $display("FAIL badsel_drain got=%b/%b exp=0/1", out_valid3, sel_err3); end
      tick();
      total++; if (sel_err3 !== 1'b0) begin bad++; $display("FAIL badsel_clear got=%b exp=0", sel_err3); end
   endtask

   task automatic test_mid_reset();
      out_ready = 1'b0; sel = 2'd3;
      in_data = 32'h1100_0000; in_valid = 4'b1000;
      tick();
      in_data = 32'h2200_0000;
      tick();
      in_valid = 4'b0000;
      total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL mrst_full got=%b exp=0000", in_ready); end
      #2;
      RST = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin bad++; $display("FAIL mrst_now got=%h/%b exp=00/0", out_data, out_valid); end
      total++; if (in_ready !== 4'b1000) begin bad++; $display("FAIL mrst_ready got=%b exp=1000", in_ready); end
      @(negedge CLK);
      RST = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mrst_after_%0d got=%b exp=0", i, out_valid); end
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_single_push();
      test_ignore_nonsel();
      test_backpressure();
      test_streaming();
      test_bad_sel();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_reg_mux

// File: doc/reg_mux.md
REG_MUX -- requirements
Module: reg_mux

Interface
REQ-001 Parameters (one per line: name, default, meaning) SHALL be:
- DATA_WIDTH, 8, width of each channel and of the output.
- NUM_CH, 4, number of input channels, 2..16.
- SEL_WIDTH, clog2(NUM_CH), select width.
REQ-002 Ports (one per line: name, direction, width, meaning) SHALL be:
- CLK, in, 1, single clock, rising edge.
- RST, in, 1, asynchronous active-low reset.
- In_Data, in, NUM_CH*DATA_WIDTH, packed channels; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- In_Valid, in, NUM_CH, per-channel valid.
- In_Ready, out, NUM_CH, per-channel ready.
- Sel, in, SEL_WIDTH, channel select.
- Out_Data, out, DATA_WIDTH, head-of-buffer data.
- Out_Valid, out, 1, Out_Data holds a valid word.
- Out_Ready, in, 1, consumer accepts the word.
- Sel_Err, out, 1, one-cycle pulse on an out-of-range select.
REQ-003 There SHALL be one clock; reset SHALL be asynchronous and active-low.

Function
REQ-004 The block SHALL be an N:1 multiplexer followed by a 2-entry output buffer (main + skid), with occupancy states EMPTY, ONE and FULL.
REQ-005 In_Ready[k] SHALL be 1 only when k == Sel, Sel < NUM_CH and the state is not FULL. All other bits SHALL be 0. In_Ready SHALL be combinational from Sel and registered state only.
REQ-006 A push SHALL occur on a cycle with In_Valid[Sel] && In_Ready[Sel]. A pop SHALL occur on a cycle with Out_Valid && Out_Ready.
REQ-007 Latency SHALL be 1 cycle: a word pushed into EMPTY appears on Out_Data with Out_Valid=1 on the next edge.
REQ-008 Transitions SHALL be:
- EMPTY + push → ONE.
- ONE + push, no pop → FULL (skid loaded).
- ONE + pop, no push → EMPTY.
- ONE + push + pop → ONE, with the head replaced by the new word.
- FULL + pop → ONE, with skid moved to head.
- FULL never pushes.
- No event → hold state.
REQ-009 Out_Data and Out_Valid SHALL be registered. Out_Data SHALL stay stable while Out_Valid=1 and Out_Ready=0.
REQ-010 Order SHALL be preserved: words leave in push order, regardless of Sel changes between pushes.
REQ-011 Sel >= NUM_CH (possible only when NUM_CH is not a power of 2) SHALL give:
- no push;
- In_Ready all 0;
- Sel_Err=1 for the cycle after each such cycle where In_Valid is nonzero.
The buffer SHALL keep draining normally.
REQ-012 Data SHALL pass unmodified, with no sign extension or truncation. Every channel SHALL be treated as unsigned bits.
REQ-013 In_Valid on non-selected channels SHALL be ignored and SHALL NOT affect state.
REQ-014 Out_Data SHALL read as 0 whenever Out_Valid=0.

Reset
REQ-015 On RST low the block SHALL immediately force state EMPTY, Out_Valid=0, Out_Data=0, Sel_Err=0 and skid contents 0. In_Ready SHALL then follow REQ-005.
REQ-016 Reset asserted mid-transfer SHALL discard all buffered words. Nothing SHALL be output after release until a new push.
REQ-017 Reset release SHALL be treated as synchronous to CLK by the system reset synchroniser. No internal synchroniser SHALL be added.

Structure
REQ-018 The occupancy-state encoding (EMPTY=2'b00, ONE=2'b01, FULL=2'b10) SHALL live in the shared system package, so the ALU and register-file buffers can reuse it.
REQ-019 The 2-entry buffer SHALL be a sub-module named skid_buf, parametrised by DATA_WIDTH. reg_mux SHALL contain the select decode, the ready fan-out and Sel_Err.

Verification
REQ-020 Reset then single push: DATA_WIDTH=8, NUM_CH=4, Sel=2, In_Data ch2=8'hA5, In_Valid=4'b0100, Out_Ready=1 → Out_Valid=1 with Out_Data=8'hA5 on the next edge, then Out_Valid=0.
REQ-021 Backpressure: Out_Ready=0 and three pushes 8'h11, 8'h22, 8'h33 → the first two are accepted, In_Ready[Sel]=0 after the second, and the third is held. Releasing Out_Ready → output order 11, 22, 33, with no loss and no duplication.
REQ-022 Streaming: Out_Ready=1 and In_Valid held for 16 cycles while Sel rotates 0,1,2,3 → 16 words out, in order, one per cycle after 1 cycle of latency.
REQ-023 Bad select: NUM_CH=3, Sel=3, In_Valid=3'b111 → In_Ready=0, Sel_Err pulses once, and the buffer state is unchanged.
REQ-024 Mid-operation reset: FULL with 8'h11 and 8'h22 buffered, RST pulsed low between edges → Out_Valid=0 immediately. After release with no input, Out_Valid stays 0.
